// File: rtl/grid_line_clear.sv
// Line-clear controller for a falling-block grid held in an external dual-port RAM.
// Scans rows bottom-up, collapses full rows by copying rows down, and blanks row 0.
module grid_line_clear #(
  parameter int COLS = 10,
  parameter int ROWS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [4:0] lines_cleared,
  input  logic [7:0] host_addr_a,
  input  logic [7:0] host_data_a,
  input  logic       host_we_a,
  input  logic [7:0] host_addr_b,
  output logic [7:0] mem_addr_a,
  output logic [7:0] mem_data_a,
  output logic       mem_we_a,
  output logic [7:0] mem_addr_b,
  input  logic [7:0] mem_q_b
);

  // Handshake: start is a level request sampled only in IDLE; busy=1 means the
  // controller owns both memory ports; done pulses for one cycle (busy=0) at the end.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    SHIFT = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [4:0] LAST_K     = 5'(COLS);
  localparam logic [4:0] LAST_COL   = 5'(COLS - 1);
  localparam logic [3:0] BOTTOM_ROW = 4'(ROWS - 1);

  state_t     state, state_next;
  logic [3:0] r, r_next;
  logic [3:0] d, d_next;
  logic [4:0] k, k_next;
  logic       row_full, row_full_next;
  logic [4:0] lines_next;

  logic [7:0] ctl_addr_a, ctl_data_a, ctl_addr_b;
  logic       ctl_we_a;
  logic       cell_ok, full_now;
  logic [3:0] src_row, prev_col;

  assign cell_ok  = (mem_q_b != 8'd0);
  assign full_now = row_full & cell_ok;
  assign src_row  = d - 4'd1;
  assign prev_col = k[3:0] - 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      r             <= BOTTOM_ROW;
      d             <= 4'd0;
      k             <= 5'd0;
      row_full      <= 1'b0;
      lines_cleared <= 5'd0;
    end else begin
      state         <= state_next;
      r             <= r_next;
      d             <= d_next;
      k             <= k_next;
      row_full      <= row_full_next;
      lines_cleared <= lines_next;
    end
  end

  always_comb begin
    state_next    = state;
    r_next        = r;
    d_next        = d;
    k_next        = k;
    row_full_next = row_full;
    lines_next    = lines_cleared;
    ctl_addr_a    = 8'd0;
    ctl_data_a    = 8'd0;
    ctl_we_a      = 1'b0;
    ctl_addr_b    = 8'd0;
    done          = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          lines_next = 5'd0;
          r_next     = BOTTOM_ROW;
          k_next     = 5'd0;
          state_next = SCAN;
        end
      end

      // Read data lags the address by one cycle, so cycle k folds in column k-1.
      SCAN: begin
        if (k < LAST_K) ctl_addr_b = {r, k[3:0]};
        if (k == LAST_K) begin
          k_next = 5'd0;
          if (full_now && r != 4'd0) begin
            d_next     = r;
            state_next = SHIFT;
          end else if (full_now) begin
            state_next = CLEAR;
          end else if (r != 4'd0) begin
            r_next = r - 4'd1;
          end else begin
            state_next = DONE;
          end
        end else begin
          k_next        = k + 5'd1;
          row_full_next = (k == 5'd0) ? 1'b1 : full_now;
        end
      end

      SHIFT: begin
        if (k < LAST_K) ctl_addr_b = {src_row, k[3:0]};
        if (k != 5'd0) begin
          ctl_we_a   = 1'b1;
          ctl_addr_a = {d, prev_col};
          ctl_data_a = mem_q_b;
        end
        if (k == LAST_K) begin
          k_next = 5'd0;
          if (d == 4'd1) state_next = CLEAR;
          else           d_next     = d - 4'd1;
        end else begin
          k_next = k + 5'd1;
        end
      end

      CLEAR: begin
        ctl_we_a   = 1'b1;
        ctl_addr_a = {4'd0, k[3:0]};
        if (k == LAST_COL) begin
          k_next     = 5'd0;
          lines_next = lines_cleared + 5'd1;
          state_next = SCAN;
        end else begin
          k_next = k + 5'd1;
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy       = (state == SCAN) || (state == SHIFT) || (state == CLEAR);
  assign mem_addr_a = busy ? ctl_addr_a : host_addr_a;
  assign mem_data_a = busy ? ctl_data_a : host_data_a;
  assign mem_we_a   = busy ? ctl_we_a   : host_we_a;
  assign mem_addr_b = busy ? ctl_addr_b : host_addr_b;

endmodule

// File: tb/tb_grid_line_clear.sv
// Bench for grid_line_clear: behavioural dual-port RAM, row-level reference model
// of the clear pass, directed scenarios and randomized grids.
module tb_grid_line_clear;

  localparam int COLS = 10;
  localparam int ROWS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done;
  logic [4:0] lines_cleared;
  logic [7:0] host_addr_a = 8'd0, host_data_a = 8'd0, host_addr_b = 8'd0;
  logic       host_we_a = 1'b0;
  logic [7:0] mem_addr_a, mem_data_a, mem_addr_b;
  logic       mem_we_a;
  logic [7:0] mem_q_b;

  int checks = 0;
  int failures = 0;

  logic [7:0] g_in  [ROWS][COLS];
  logic [7:0] g_exp [ROWS][COLS];
  logic [7:0] g_act [ROWS][COLS];
  int exp_lines, exp_busy, exp_we;

  int   busy_n, we_n;
  bit   timed_out, done_at_end, done_after, busy_after;
  logic [4:0] lines_at_done, lines_after;

  grid_line_clear #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .lines_cleared(lines_cleared),
    .host_addr_a(host_addr_a), .host_data_a(host_data_a), .host_we_a(host_we_a),
    .host_addr_b(host_addr_b),
    .mem_addr_a(mem_addr_a), .mem_data_a(mem_data_a), .mem_we_a(mem_we_a),
    .mem_addr_b(mem_addr_b), .mem_q_b(mem_q_b)
  );

  // Clock / reset and grid memory
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_we_a) mem[mem_addr_a] <= mem_data_a;
    mem_q_b <= mem[mem_addr_b];
  end

  // Reference model: repeatedly remove the lowest full row, letting everything above fall.
  task automatic model_pass();
    logic [7:0] w [ROWS][COLS];
    int r;
    bit full;
    w = g_in;
    exp_lines = 0;
    exp_busy  = 0;
    exp_we    = 0;
    r = ROWS - 1;
    while (1) begin
      exp_busy += COLS + 1;
      full = 1;
      for (int c = 0; c < COLS; c++) if (w[r][c] == 8'd0) full = 0;
      if (full) begin
        exp_lines++;
        exp_busy += r * (COLS + 1) + COLS;
        exp_we   += r * COLS + COLS;
        for (int i = r; i > 0; i--) w[i] = w[i-1];
        for (int c = 0; c < COLS; c++) w[0][c] = 8'd0;
      end else if (r == 0) begin
        break;
      end else begin
        r--;
      end
    end
    g_exp = w;
  endtask

  // Driver tasks
  task automatic host_write(input int r, input int c, input logic [7:0] v);
    @(negedge clk);
    host_addr_a = {r[3:0], c[3:0]};
    host_data_a = v;
    host_we_a   = 1'b1;
  endtask

  task automatic host_read(input int r, input int c, output logic [7:0] v);
    @(negedge clk);
    host_we_a   = 1'b0;
    host_addr_b = {r[3:0], c[3:0]};
    @(negedge clk);
    v = mem_q_b;
  endtask

  task automatic load_grid();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) host_write(r, c, g_in[r][c]);
    @(negedge clk);
    host_we_a = 1'b0;
  endtask

  task automatic read_grid();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) host_read(r, c, g_act[r][c]);
  endtask

  task automatic clear_g_in();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) g_in[r][c] = 8'd0;
  endtask

  // Runs one pass; start is also raised in the DONE cycle, where it must be ignored.
  task automatic run_pass();
    busy_n = 0;
    we_n   = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (busy === 1'b1 && busy_n < 5000) begin
      busy_n++;
      if (mem_we_a) we_n++;
      @(negedge clk);
    end
    timed_out     = (busy !== 1'b0);
    done_at_end   = done;
    lines_at_done = lines_cleared;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    done_after = done;
    @(negedge clk);
    busy_after  = busy;
    lines_after = lines_cleared;
  endtask

  task automatic run_and_verify(input string name);
    int shown;
    model_pass();
    load_grid();
    run_pass();
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL %s timeout busy_cycles=%0d", name, busy_n);
    end
    checks++;
    if (busy_n !== exp_busy) begin
      failures++;
      $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_n, exp_busy);
    end
    checks++;
    if (we_n !== exp_we) begin
      failures++;
      $display("FAIL %s we_cycles got=%0d exp=%0d", name, we_n, exp_we);
    end
    checks++;
    if (done_at_end !== 1'b1 || done_after !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse got=%b%b exp=10", name, done_at_end, done_after);
    end
    checks++;
    if (lines_at_done !== 5'(exp_lines) || lines_after !== 5'(exp_lines)) begin
      failures++;
      $display("FAIL %s lines_cleared got=%0d/%0d exp=%0d", name, lines_at_done, lines_after,
               exp_lines);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      failures++;
      $display("FAIL %s start_in_done got_busy=%b exp=0", name, busy_after);
    end
    read_grid();
    shown = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        checks++;
        if (g_act[r][c] !== g_exp[r][c]) begin
          failures++;
          if (shown < 8)
            $display("FAIL %s cell(%0d,%0d) got=%0d exp=%0d", name, r, c, g_act[r][c],
                     g_exp[r][c]);
          shown++;
        end
      end
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1'b1;
    host_addr_a = 8'h12;
    host_addr_b = 8'h34;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || lines_cleared !== 5'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b lines=%0d exp 0/0/0", busy, done,
               lines_cleared);
    end
    checks++;
    if (mem_addr_a !== 8'h12 || mem_addr_b !== 8'h34 || mem_we_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_passthru got a=%h b=%h we=%b exp 12/34/0", mem_addr_a, mem_addr_b,
               mem_we_a);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_empty();
    clear_g_in();
    run_and_verify("empty");
    checks++;
    if (busy_n !== 176 || we_n !== 0) begin
      failures++;
      $display("FAIL empty_fixed got busy=%0d we=%0d exp 176/0", busy_n, we_n);
    end
  endtask

  task automatic test_single_line();
    clear_g_in();
    for (int c = 0; c < COLS; c++) g_in[15][c] = 8'd1;
    g_in[14][3] = 8'd5;
    run_and_verify("single_line");
    checks++;
    if (g_act[15][3] !== 8'd5 || g_act[15][0] !== 8'd0 || lines_at_done !== 5'd1) begin
      failures++;
      $display("FAIL single_fixed got (15,3)=%0d (15,0)=%0d lines=%0d exp 5/0/1", g_act[15][3],
               g_act[15][0], lines_at_done);
    end
  endtask

  task automatic test_four_lines();
    clear_g_in();
    for (int r = 12; r < 16; r++)
      for (int c = 0; c < COLS; c++) g_in[r][c] = 8'($urandom_range(1, 255));
    g_in[11][0] = 8'd7;
    run_and_verify("four_lines");
    checks++;
    if (g_act[15][0] !== 8'd7 || lines_at_done !== 5'd4) begin
      failures++;
      $display("FAIL four_fixed got (15,0)=%0d lines=%0d exp 7/4", g_act[15][0], lines_at_done);
    end
  endtask

  task automatic test_row0_only();
    clear_g_in();
    for (int c = 0; c < COLS; c++) g_in[0][c] = 8'd3;
    run_and_verify("row0_only");
    checks++;
    if (we_n !== COLS || lines_at_done !== 5'd1) begin
      failures++;
      $display("FAIL row0_fixed got we=%0d lines=%0d exp %0d/1", we_n, lines_at_done, COLS);
    end
  endtask

  task automatic test_host_block();
    logic [7:0] v;
    int guard;
    clear_g_in();
    load_grid();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    host_addr_a = 8'h00;
    host_data_a = 8'd9;
    host_we_a   = 1'b1;
    guard = 0;
    while (busy === 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    host_we_a = 1'b0;
    checks++;
    if (guard == 0 || guard >= 1000) begin
      failures++;
      $display("FAIL host_block_pass got busy_cycles=%0d exp 1..999", guard);
    end
    host_read(0, 0, v);
    checks++;
    if (v !== 8'd0) begin
      failures++;
      $display("FAIL host_write_while_busy got=%0d exp=0", v);
    end
    host_write(0, 0, 8'd9);
    host_read(0, 0, v);
    checks++;
    if (v !== 8'd9) begin
      failures++;
      $display("FAIL host_write_idle got=%0d exp=9", v);
    end
  endtask

  task automatic test_reset_mid_shift();
    int guard;
    clear_g_in();
    for (int r = 14; r < 16; r++)
      for (int c = 0; c < COLS; c++) g_in[r][c] = 8'd2;
    g_in[13][4] = 8'd6;
    load_grid();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    guard = 0;
    while (!(lines_cleared === 5'd1 && mem_we_a === 1'b1 && busy === 1'b1) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 1000) begin
      failures++;
      $display("FAIL reset_mid_shift_reach got=timeout exp=second_shift");
    end
    reset = 1'b1;
    host_addr_a = 8'h5a;
    host_data_a = 8'h33;
    host_addr_b = 8'ha5;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || lines_cleared !== 5'd0 || mem_we_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_shift got busy=%b done=%b lines=%0d we=%b exp 0/0/0/0", busy,
               done, lines_cleared, mem_we_a);
    end
    checks++;
    if (mem_addr_a !== 8'h5a || mem_data_a !== 8'h33 || mem_addr_b !== 8'ha5) begin
      failures++;
      $display("FAIL reset_mid_shift_passthru got a=%h d=%h b=%h exp 5a/33/a5", mem_addr_a,
               mem_data_a, mem_addr_b);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_shift_idle got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      for (int r = 0; r < ROWS; r++) begin
        if ($urandom_range(0, 2) == 0) begin
          for (int c = 0; c < COLS; c++) g_in[r][c] = 8'($urandom_range(1, 255));
        end else begin
          for (int c = 0; c < COLS; c++) g_in[r][c] = 8'($urandom_range(0, 3));
          g_in[r][$urandom_range(0, COLS - 1)] = 8'd0;
        end
      end
      run_and_verify($sformatf("random%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single_line();
    test_four_lines();
    test_row0_only();
    test_host_block();
    test_reset_mid_shift();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
